// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
// bru_entry_t is the default-width queue entry layout; the top re-declares
// the same fields at its own parameterised widths for the queue payload.
package bru_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } bru_state_t;

   localparam int BRU_PC_W  = 32;
   localparam int BRU_IDX_W = 6;

   typedef struct packed {
      logic [BRU_IDX_W-1:0] idx;
      logic                 taken;
      logic [BRU_PC_W-1:0]  target;
      logic [BRU_PC_W-1:0]  pc;
   } bru_entry_t;

   // Sequential next-PC step for a not-taken branch.
   localparam int PC_INC = 4;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute <-> branch resolve unit signal bundle.
// master: fetch/execute side; slave: branch_resolve_unit.
// Optional macro BRU_STATS_EN adds the statistics counter outputs.
interface branch_resolve_unit_if #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
);

   logic                     pred_valid;
   logic                     pred_ready;
   logic [IDX_W-1:0]         pred_idx;
   logic                     pred_taken;
   logic [PC_W-1:0]          pred_target;
   logic [PC_W-1:0]          pred_pc;

   logic                     res_valid;
   logic                     res_taken;
   logic [PC_W-1:0]          res_target;

   logic                     upd_valid;
   logic [IDX_W-1:0]         upd_idx;
   logic                     upd_taken;

   logic                     flush;
   logic [PC_W-1:0]          redirect_pc;
   logic [$clog2(DEPTH):0]   occupancy;
   logic                     err_unexpected;

`ifdef BRU_STATS_EN
   logic [CNT_W-1:0]         stat_branches;
   logic [CNT_W-1:0]         stat_mispredicts;
`endif

   modport master (
      output pred_valid, pred_idx, pred_taken, pred_target, pred_pc,
      output res_valid, res_taken, res_target,
      input  pred_ready, upd_valid, upd_idx, upd_taken,
      input  flush, redirect_pc, occupancy, err_unexpected
`ifdef BRU_STATS_EN
      , input stat_branches, stat_mispredicts
`endif
   );

   modport slave (
      input  pred_valid, pred_idx, pred_taken, pred_target, pred_pc,
      input  res_valid, res_taken, res_target,
      output pred_ready, upd_valid, upd_idx, upd_taken,
      output flush, redirect_pc, occupancy, err_unexpected
`ifdef BRU_STATS_EN
      , output stat_branches, stat_mispredicts
`endif
   );

endinterface

// File: rtl/bru_queue.sv
// In-order circular FIFO of predicted branches. Synchronous clear has
// priority over push/pop so a push in a clearing cycle is dropped.
// The caller never pushes when full or pops when empty.
module bru_queue
   import bru_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = bru_entry_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clr,
   input  entry_t                 push_entry,
   output entry_t                 head_entry,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;

   // Pointer and count bookkeeping; pointers wrap naturally (DEPTH is 2^AW)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clr) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (pop)  head <= head + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage is payload only and carries no reset
   always_ff @(posedge clk) begin
      if (push && !clr) mem[tail] <= push_entry;
   end

   assign head_entry = mem[head];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks each in-order resolve against the oldest
// queued prediction, emits a training strobe on every resolve and a
// one-cycle flush with the correct redirect PC on a mispredict.
// Optional macro BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   branch_resolve_unit_if.slave  bus
);

   localparam int OCC_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             taken;
      logic [PC_W-1:0]  target;
      logic [PC_W-1:0]  pc;
   } entry_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   bru_state_t        state;
   logic [OCC_W-1:0]  occ;
   entry_t            head_p0;
   entry_t            push_entry_p0;
   logic              pred_ready_p0;
   logic              push_p0;
   logic              pop_p0;
   logic              unexp_p0;
   logic              mispredict_p0;
   logic [PC_W-1:0]   redirect_p0;

   logic              upd_vld_p1;
   logic [IDX_W-1:0]  upd_idx_p1;
   logic              upd_taken_p1;
   logic              flush_p1;
   logic [PC_W-1:0]   redirect_pc_p1;
   logic              err_p1;

   // ---- stage p0: resolve compare against the queue head ----
   assign pred_ready_p0 = (state == RUN) && (occ < OCC_W'(DEPTH));
   assign push_p0       = bus.pred_valid && pred_ready_p0;
   assign pop_p0        = bus.res_valid && (occ != '0);
   assign unexp_p0      = bus.res_valid && (occ == '0);
   assign mispredict_p0 = pop_p0 &&
                          ((bus.res_taken != head_p0.taken) ||
                           (bus.res_taken && (bus.res_target != head_p0.target)));
   assign redirect_p0   = bus.res_taken ? bus.res_target
                                        : head_p0.pc + PC_W'(PC_INC);

   assign push_entry_p0 = '{idx:    bus.pred_idx,
                            taken:  bus.pred_taken,
                            target: bus.pred_target,
                            pc:     bus.pred_pc};

   bru_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_p0),
      .pop        (pop_p0),
      .clr        (mispredict_p0),
      .push_entry (push_entry_p0),
      .head_entry (head_p0),
      .count      (occ)
   );

   // ---- stage p1: registered strobes, payloads and recovery FSM ----
   // FSM plus registered training/flush/error outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= RUN;
         upd_vld_p1     <= 1'b0;
         upd_idx_p1     <= '0;
         upd_taken_p1   <= 1'b0;
         flush_p1       <= 1'b0;
         redirect_pc_p1 <= '0;
         err_p1         <= 1'b0;
      end else begin
         upd_vld_p1 <= pop_p0;
         flush_p1   <= mispredict_p0;
         err_p1     <= unexp_p0;
         if (pop_p0) begin
            upd_idx_p1   <= head_p0.idx;
            upd_taken_p1 <= bus.res_taken;
         end
         if (mispredict_p0) redirect_pc_p1 <= redirect_p0;
         case (state)
            RUN:     if (mispredict_p0) state <= RECOVER;
            RECOVER: state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   assign bus.pred_ready     = pred_ready_p0;
   assign bus.occupancy      = occ;
   assign bus.upd_valid      = upd_vld_p1;
   assign bus.upd_idx        = upd_idx_p1;
   assign bus.upd_taken      = upd_taken_p1;
   assign bus.flush          = flush_p1;
   assign bus.redirect_pc    = redirect_pc_p1;
   assign bus.err_unexpected = err_p1;

`ifdef BRU_STATS_EN
   logic [CNT_W-1:0] stat_br_p1;
   logic [CNT_W-1:0] stat_mp_p1;

   // Saturating resolve and mispredict counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_br_p1 <= '0;
         stat_mp_p1 <= '0;
      end else begin
         if (pop_p0)        stat_br_p1 <= sat_inc(stat_br_p1);
         if (mispredict_p0) stat_mp_p1 <= sat_inc(stat_mp_p1);
      end
   end

   assign bus.stat_branches    = stat_br_p1;
   assign bus.stat_mispredicts = stat_mp_p1;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit. Expected strobes are queued
// one cycle ahead by a reference model and popped at the falling edge.
// Statistics checks are compiled only with BRU_STATS_EN.
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int IDX_W = 6;
   localparam int CNT_W = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

   branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic             taken;
      logic [PC_W-1:0]  target;
      logic [PC_W-1:0]  pc;
   } pred_t;

   typedef struct {
      logic             upd;
      logic [IDX_W-1:0] idx;
      logic             taken;
      logic             flush;
      logic [PC_W-1:0]  redirect;
      logic             err;
   } exp_t;

   pred_t mq[$];
   exp_t  sb[$];
   exp_t  me;
   bit    m_recover = 1'b0;
   bit    mon_en = 1'b0;
   int    m_br = 0;
   int    m_mp = 0;
   int    n_checks = 0;
   int    n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v < (1 << CNT_W) - 1) ? v + 1 : v;
   endfunction

   task automatic drive_idle();
      bus.pred_valid  = 1'b0;
      bus.pred_idx    = '0;
      bus.pred_taken  = 1'b0;
      bus.pred_target = '0;
      bus.pred_pc     = '0;
      bus.res_valid   = 1'b0;
      bus.res_taken   = 1'b0;
      bus.res_target  = '0;
   endtask

   // One clock cycle of stimulus; entered and left just after a rising edge.
   task automatic step(input bit pv, input logic [IDX_W-1:0] idx, input bit tk,
                       input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] pc,
                       input bit rv, input bit rt, input logic [PC_W-1:0] rtgt);
      bit    m_ready, acc, mp, has_ev;
      exp_t  e;
      pred_t h;
      bus.pred_valid  = pv;
      bus.pred_idx    = idx;
      bus.pred_taken  = tk;
      bus.pred_target = tgt;
      bus.pred_pc     = pc;
      bus.res_valid   = rv;
      bus.res_taken   = rt;
      bus.res_target  = rtgt;
      m_ready = !m_recover && (mq.size() < DEPTH);
      #1 check("pred_ready", bus.pred_ready, m_ready);
      acc = pv && m_ready;
      mp = 1'b0;
      has_ev = 1'b0;
      e = '{upd: 1'b0, idx: '0, taken: 1'b0, flush: 1'b0, redirect: '0, err: 1'b0};
      if (rv) begin
         has_ev = 1'b1;
         if (mq.size() == 0) begin
            e.err = 1'b1;
         end else begin
            h = mq.pop_front();
            mp = (rt != h.taken) || (rt && (rtgt != h.target));
            e.upd = 1'b1;
            e.idx = h.idx;
            e.taken = rt;
            e.flush = mp;
            e.redirect = rt ? rtgt : h.pc + PC_W'(4);
            m_br = sat(m_br);
            if (mp) begin
               m_mp = sat(m_mp);
               mq.delete();
            end
         end
      end
      if (acc && !mp) mq.push_back('{idx: idx, taken: tk, target: tgt, pc: pc});
      m_recover = mp;
      @(posedge clk);
      #1;
      drive_idle();
      if (has_ev) sb.push_back(e);
      check("occupancy", bus.occupancy, mq.size());
   endtask

   task automatic push(input logic [IDX_W-1:0] idx, input bit tk,
                       input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] pc);
      step(1'b1, idx, tk, tgt, pc, 1'b0, 1'b0, '0);
   endtask

   task automatic resolve(input bit rt, input logic [PC_W-1:0] rtgt);
      step(1'b0, '0, 1'b0, '0, '0, 1'b1, rt, rtgt);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
   endtask

   // Compare DUT strobes one cycle after the model queued them
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() != 0) begin
            me = sb.pop_front();
            check("upd_valid", bus.upd_valid, me.upd);
            if (me.upd) begin
               check("upd_idx", bus.upd_idx, me.idx);
               check("upd_taken", bus.upd_taken, me.taken);
            end
            check("flush", bus.flush, me.flush);
            if (me.flush) check("redirect_pc", bus.redirect_pc, me.redirect);
            check("err_unexpected", bus.err_unexpected, me.err);
         end else if (bus.upd_valid || bus.flush || bus.err_unexpected) begin
            check("spurious_strobe", {bus.upd_valid, bus.flush, bus.err_unexpected}, 3'b000);
         end
      end
   end

   initial begin
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pred_ready", bus.pred_ready, 1'b1);
      check("rst_occupancy", bus.occupancy, 0);
      check("rst_upd_valid", bus.upd_valid, 1'b0);
      check("rst_upd_idx", bus.upd_idx, 0);
      check("rst_upd_taken", bus.upd_taken, 1'b0);
      check("rst_flush", bus.flush, 1'b0);
      check("rst_redirect_pc", bus.redirect_pc, 0);
      check("rst_err", bus.err_unexpected, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Correct taken prediction: train only
      push(6'd5, 1'b1, 32'h200, 32'h100);
      resolve(1'b1, 32'h200);
      idle();

      // Predicted not-taken, actually taken: flush then one RECOVER cycle
      push(6'd7, 1'b0, 32'h0, 32'h100);
      resolve(1'b1, 32'h300);
      step(1'b1, 6'd9, 1'b0, 32'h0, 32'h104, 1'b0, 1'b0, '0);
      idle();

      // Mispredict on the oldest of three; same-cycle push is discarded
      push(6'd1, 1'b1, 32'h80, 32'h40);
      push(6'd2, 1'b0, 32'h0, 32'h50);
      push(6'd3, 1'b1, 32'h90, 32'h60);
      step(1'b1, 6'd4, 1'b0, 32'h0, 32'h70, 1'b1, 1'b0, 32'h0);
      idle();
      idle();
      idle();

      // Fill to DEPTH, push while full, then drain with mixed outcomes
      for (int i = 0; i < DEPTH; i++) begin
         push(IDX_W'(8 + i), (i % 2) == 1, PC_W'(32'h1000 + 16 * i), PC_W'(32'h200 + 4 * i));
      end
      step(1'b1, 6'd20, 1'b0, 32'h0, 32'h300, 1'b0, 1'b0, '0);
      resolve(1'b0, 32'hdead);
      step(1'b1, 6'd21, 1'b0, 32'h0, 32'h304, 1'b1, 1'b1, 32'h1010);
      resolve(1'b0, 32'h0);
      resolve(1'b1, 32'h1034);
      idle();
      idle();

      // Resolve with nothing queued
      resolve(1'b1, 32'h500);
      idle();

      // Random traffic against the model
      for (int i = 0; i < 60; i++) begin
         step($urandom_range(0, 1) == 1, IDX_W'($urandom_range(0, 63)),
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1) ? PC_W'(32'h1000) : PC_W'(32'h2000),
              PC_W'($urandom_range(0, 255) * 4),
              $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1) ? PC_W'(32'h1000) : PC_W'(32'h2000));
      end
      idle();
      idle();

      // Asynchronous reset while a flush strobe is high
      push(6'd11, 1'b1, 32'h700, 32'h600);
      push(6'd12, 1'b0, 32'h0, 32'h604);
      resolve(1'b0, 32'h0);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_flush", bus.flush, 1'b0);
      check("arst_upd_valid", bus.upd_valid, 1'b0);
      check("arst_redirect_pc", bus.redirect_pc, 0);
      check("arst_upd_idx", bus.upd_idx, 0);
      check("arst_occupancy", bus.occupancy, 0);
      sb.delete();
      mq.delete();
      m_recover = 1'b0;
      m_br = 0;
      m_mp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      idle();

`ifdef BRU_STATS_EN
      // Five resolves, four mispredicts: both counters saturate at 3
      push(6'd1, 1'b1, 32'h10, 32'h0);
      resolve(1'b1, 32'h10);
      for (int i = 0; i < 4; i++) begin
         push(6'd2, 1'b0, 32'h0, 32'h20);
         resolve(1'b1, 32'h30);
         idle();
      end
      idle();
      check("stat_branches", bus.stat_branches, m_br);
      check("stat_mispredicts", bus.stat_mispredicts, m_mp);
`endif

      idle();
      check("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
